// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC output arbiters and VC allocator.
package noc_arb_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int MAX_PORTS  = 16;

    typedef enum logic [2:0] {
        DIR_N = 3'd0,
        DIR_S = 3'd1,
        DIR_W = 3'd2,
        DIR_E = 3'd3,
        DIR_L = 3'd4
    } dir_e;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    function automatic int onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_mask_picker.sv
// Rotating-priority picker: first set bit of desire scanning ptr+1, ptr+2, ... modulo N_PORTS.
module rr_mask_picker
    import noc_arb_pkg::*;
#(
    parameter int N_PORTS = 5,
    parameter int IDX_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] desire,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] pick_oh,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_valid
);

    logic             found;
    logic [IDX_W-1:0] scan_idx;

    always_comb begin
        pick_oh  = '0;
        found    = 1'b0;
        scan_idx = '0;
        // The last-served index is visited last, giving it lowest priority.
        for (int k = 1; k <= N_PORTS; k++) begin
            scan_idx = IDX_W'((int'(ptr) + k) % N_PORTS);
            if (!found && desire[scan_idx]) begin
                pick_oh[scan_idx] = 1'b1;
                found             = 1'b1;
            end
        end
    end

    assign pick_valid = |desire;
    assign pick_idx   = IDX_W'(onehot_to_idx(MAX_PORTS'(pick_oh)));

endmodule

// File: rtl/rr_output_arbiter.sv
// Round-robin wormhole arbiter for one router output port.
// Optional stall-release timer enabled by defining ARB_HOLD_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no packet owns the output; pick the next desired requester
// LOCKED | grant held for requester grant_idx_o until its tail flit transfers
module rr_output_arbiter
    import noc_arb_pkg::*;
#(
    parameter int N_PORTS   = 5,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int OUT_DIR   = DIR_W,
    parameter int MAX_STALL = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_PORTS-1:0]           req_valid_i,
    input  logic [N_PORTS*ADDR_W-1:0]    req_nexthop_addr_i,
    input  logic [N_PORTS-1:0]           req_tail_i,
    input  logic                         out_ready_i,
    output logic [N_PORTS-1:0]           grant_o,
    output logic [$clog2(N_PORTS)-1:0]   grant_idx_o,
    output logic                         grant_valid_o,
    output logic                         xfer_o,
    output logic [$clog2(N_PORTS)-1:0]   rr_ptr_o,
    output logic                         timeout_o
);

    localparam int IDX_W = $clog2(N_PORTS);

    arb_state_e         state;
    logic [N_PORTS-1:0] desire;
    logic [N_PORTS-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               tail_done;
    logic               stall_done;

    always_comb begin
        desire = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            desire[i] = req_valid_i[i]
                      && (req_nexthop_addr_i[i*ADDR_W +: ADDR_W] == ADDR_W'(OUT_DIR))
                      && (i != OUT_DIR);
        end
    end

    rr_mask_picker #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_picker (
        .desire     (desire),
        .ptr        (rr_ptr_o),
        .pick_oh    (pick_oh),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    assign xfer_o    = grant_valid_o & req_valid_i[grant_idx_o] & out_ready_i;
    assign tail_done = xfer_o & req_tail_i[grant_idx_o];

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int STALL_W = $clog2(MAX_STALL);
    localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(MAX_STALL - 1);

    logic [STALL_W-1:0] stall_cnt;

    // Down-counter reloads while idle and on every transfer; terminal count forces release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= STALL_LOAD;
        end else if (state == IDLE || xfer_o) begin
            stall_cnt <= STALL_LOAD;
        end else if (stall_cnt != '0) begin
            stall_cnt <= stall_cnt - 1'b1;
        end
    end

    assign stall_done = (state == LOCKED) && !xfer_o && (stall_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) timeout_o <= 1'b0;
        else        timeout_o <= stall_done;
    end
`else
    assign stall_done = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            grant_o       <= '0;
            grant_idx_o   <= '0;
            grant_valid_o <= 1'b0;
            rr_ptr_o      <= IDX_W'(N_PORTS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state         <= LOCKED;
                        grant_o       <= pick_oh;
                        grant_idx_o   <= pick_idx;
                        grant_valid_o <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (tail_done || stall_done) begin
                        state         <= IDLE;
                        grant_o       <= '0;
                        grant_idx_o   <= '0;
                        grant_valid_o <= 1'b0;
                        rr_ptr_o      <= grant_idx_o;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Scoreboard bench for rr_output_arbiter (N_PORTS=5, OUT_DIR=2, ADDR_W=3).
module tb_rr_output_arbiter;

    localparam int N  = 5;
    localparam int AW = 3;
`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int STALL_CLKS = 5;
`else
    localparam int STALL_CLKS = 10;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req_valid;
    logic [AW-1:0] addr [N];
    logic [N*AW-1:0] req_nexthop_addr;
    logic [N-1:0]  req_tail;
    logic          out_ready;
    logic [N-1:0]  grant_o;
    logic [2:0]    grant_idx_o;
    logic          grant_valid_o;
    logic          xfer_o;
    logic [2:0]    rr_ptr_o;
    logic          timeout_o;

    assign req_nexthop_addr = {addr[4], addr[3], addr[2], addr[1], addr[0]};

    rr_output_arbiter #(
        .N_PORTS   (N),
        .ADDR_W    (AW),
        .OUT_DIR   (2),
        .MAX_STALL (8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid_i        (req_valid),
        .req_nexthop_addr_i (req_nexthop_addr),
        .req_tail_i         (req_tail),
        .out_ready_i        (out_ready),
        .grant_o            (grant_o),
        .grant_idx_o        (grant_idx_o),
        .grant_valid_o      (grant_valid_o),
        .xfer_o             (xfer_o),
        .rr_ptr_o           (rr_ptr_o),
        .timeout_o          (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = transfer, 1 = timeout
        int cyc;
        int idx;
        int ptr;
    } ev_t;

    ev_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int ec, input int idx, input int ptr);
        ev_t e;
        e.kind = kind;
        e.cyc  = ec;
        e.idx  = idx;
        e.ptr  = ptr;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk(kind == 0 ? "unexpected_xfer" : "unexpected_timeout", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_cycle", cyc, e.cyc);
            if (kind == 0) begin
                chk("ev_grant_idx", int'(grant_idx_o), e.idx);
                chk("ev_grant_oh", int'(grant_o), 1 << e.idx);
            end else begin
                chk("ev_grant_valid", int'(grant_valid_o), 0);
            end
            chk("ev_rr_ptr", int'(rr_ptr_o), e.ptr);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (xfer_o)    check_ev(0);
            if (timeout_o) check_ev(1);
        end
    end

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_tail  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) addr[i] = '0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b0;
        go(3);
        chk("rst_grant", int'(grant_o), 0);
        chk("rst_grant_idx", int'(grant_idx_o), 0);
        chk("rst_grant_valid", int'(grant_valid_o), 0);
        chk("rst_timeout", int'(timeout_o), 0);
        chk("rst_rr_ptr", int'(rr_ptr_o), 4);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            go(1);
            chk("idle_grant", int'(grant_o), 0);
            chk("idle_grant_valid", int'(grant_valid_o), 0);
            chk("idle_rr_ptr", int'(rr_ptr_o), 4);
        end

        // Rotation among ports 0,3,4 with single-flit packets
        c = cyc;
        req_valid = 5'b11001;
        for (int i = 0; i < N; i++) addr[i] = 3'd2;
        req_tail  = 5'b11111;
        out_ready = 1'b1;
        expect_ev(0, c + 1, 0, 4);
        expect_ev(0, c + 3, 3, 0);
        expect_ev(0, c + 5, 4, 3);
        expect_ev(0, c + 7, 0, 4);
        go(8);
        req_valid = '0;
        go(2);
        chk("rot_end_ptr", int'(rr_ptr_o), 0);
        chk("rot_end_valid", int'(grant_valid_o), 0);

        // Own direction and wrong next hop are never granted
        req_valid = 5'b00110;
        addr[2]   = 3'd2;
        addr[1]   = 3'd3;
        go(10);
        chk("filter_grant_valid", int'(grant_valid_o), 0);
        chk("filter_xfer", int'(xfer_o), 0);
        clear_inputs();
        go(2);

        // Port 1 four-flit packet, port 0 joins from flit 2
        c = cyc;
        req_valid[1] = 1'b1;
        addr[1]      = 3'd2;
        out_ready    = 1'b1;
        for (int i = 1; i <= 4; i++) expect_ev(0, c + i, 1, 0);
        expect_ev(0, c + 6, 0, 1);
        go(2);
        req_valid[0] = 1'b1;
        addr[0]      = 3'd2;
        req_tail[0]  = 1'b1;
        go(2);
        req_tail[1] = 1'b1;
        chk("wh_hold_grant", int'(grant_o), 5'b00010);
        go(1);
        req_valid[1] = 1'b0;
        chk("wh_bubble", int'(grant_valid_o), 0);
        chk("wh_ptr_after_tail", int'(rr_ptr_o), 1);
        go(1);
        chk("wh_next_grant", int'(grant_o), 5'b00001);
        go(1);
        req_valid[0] = 1'b0;
        go(2);
        clear_inputs();

        // Lock on port 3 with downstream back-pressure
        c = cyc;
        req_valid[3] = 1'b1;
        addr[3]      = 3'd2;
        req_tail[3]  = 1'b1;
        out_ready    = 1'b0;
        expect_ev(0, c + 1 + STALL_CLKS, 3, 0);
        go(3);
        chk("bp_grant_held", int'(grant_o), 5'b01000);
        chk("bp_no_xfer", int'(xfer_o), 0);
        go(STALL_CLKS - 2);
        chk("bp_still_held", int'(grant_o), 5'b01000);
        out_ready = 1'b1;
        go(1);
        req_valid = '0;
        out_ready = 1'b0;
        chk("bp_released", int'(grant_valid_o), 0);
        chk("bp_ptr", int'(rr_ptr_o), 3);
        go(2);
        clear_inputs();

`ifdef ARB_HOLD_TIMEOUT_EN
        // Forced release after MAX_STALL stalled cycles
        c = cyc;
        req_valid[4] = 1'b1;
        addr[4]      = 3'd2;
        req_tail[4]  = 1'b1;
        out_ready    = 1'b0;
        expect_ev(1, c + 9, 0, 4);
        go(8);
        chk("to_still_locked", int'(grant_o), 5'b10000);
        go(1);
        req_valid = '0;
        chk("to_released", int'(grant_valid_o), 0);
        chk("to_ptr", int'(rr_ptr_o), 4);
        go(2);
        chk("to_single_pulse", int'(timeout_o), 0);
        clear_inputs();
`endif

        // Asynchronous reset in the middle of a locked packet
        req_valid[0] = 1'b1;
        addr[0]      = 3'd2;
        req_tail[0]  = 1'b0;
        out_ready    = 1'b0;
        go(2);
        chk("ar_locked", int'(grant_o), 5'b00001);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_grant", int'(grant_o), 0);
        chk("ar_grant_valid", int'(grant_valid_o), 0);
        chk("ar_rr_ptr", int'(rr_ptr_o), 4);
        clear_inputs();
        go(2);
        reset = 1'b1;
        go(2);
        chk("ar_after_release", int'(grant_valid_o), 0);

        go(3);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
